// File: rtl/ifid_hazard_ctrl.sv
// IF/ID sequencing controller: load-use, imem miss, mispredict and
// exception arbitration driving PC / IFID / IDEX write controls.
module ifid_hazard_ctrl #(
   parameter int unsigned EXC_DRAIN    = 2,
   parameter int unsigned MISS_TIMEOUT = 64,
   parameter int unsigned CNT_W        = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             IDEX_MemRead,
   input  logic [4:0]       IDEX_Rt,
   input  logic [4:0]       IFID_Rs,
   input  logic [4:0]       IFID_Rt,
   input  logic             IFID_UsesRt,
   input  logic             ImemReady,
   input  logic             BrMispredict,
   input  logic             Exception,
   output logic             PCWrite,
   output logic             IF_ID_Write,
   output logic             IF_ID_Flush_excep,
   output logic             ID_EX_Bubble,
   output logic             ExcepPCSel,
   output logic             ImemTimeout,
   output logic [CNT_W-1:0] StallCnt
);

   typedef enum logic [1:0] {
      S_RUN,
      S_IMISS,
      S_EXC
   } state_e;

   localparam logic [3:0] DRAIN_INIT = 4'(EXC_DRAIN);
   localparam logic [7:0] MISS_LAST  = 8'(MISS_TIMEOUT - 1);

   state_e           state_q, state_d;
   logic [3:0]       drain_q, drain_d;
   logic [7:0]       miss_q, miss_d;
   logic             timeout_q, timeout_d;
   logic [CNT_W-1:0] stall_q, stall_d;

   logic lu;
   logic take_exc;
   logic pc_we, ifid_we, flush, bubble, exc_sel;

   always_comb begin
      lu = IDEX_MemRead && (IDEX_Rt != 5'd0) &&
           ((IDEX_Rt == IFID_Rs) ||
            (IFID_UsesRt && (IDEX_Rt == IFID_Rt)));

      pc_we     = 1'b1;
      ifid_we   = 1'b1;
      flush     = 1'b0;
      bubble    = 1'b0;
      exc_sel   = 1'b0;
      take_exc  = 1'b0;
      state_d   = state_q;
      drain_d   = drain_q;
      miss_d    = miss_q;
      timeout_d = timeout_q;

      unique case (state_q)
         S_RUN: begin
            if (Exception) begin
               take_exc = 1'b1;
            end else if (BrMispredict) begin
               flush = 1'b1;
            end else if (!ImemReady) begin
               pc_we   = 1'b0;
               flush   = 1'b1;
               miss_d  = 8'd0;
               state_d = S_IMISS;
            end else if (lu) begin
               pc_we   = 1'b0;
               ifid_we = 1'b0;
               bubble  = 1'b1;
            end
         end
         S_IMISS: begin
            miss_d = miss_q + 8'd1;
            if (Exception) begin
               take_exc = 1'b1;
            end else if (BrMispredict) begin
               flush   = 1'b1;
               miss_d  = 8'd0;
               state_d = S_RUN;
            end else if (ImemReady) begin
               state_d = S_RUN;
               if (lu) begin
                  pc_we   = 1'b0;
                  ifid_we = 1'b0;
                  bubble  = 1'b1;
               end
            end else if (miss_q == MISS_LAST) begin
               // Watchdog: treat a stuck fetch as an exception
               take_exc  = 1'b1;
               timeout_d = 1'b1;
            end else begin
               pc_we = 1'b0;
               flush = 1'b1;
            end
         end
         S_EXC: begin
            pc_we   = 1'b0;
            flush   = 1'b1;
            bubble  = 1'b1;
            drain_d = drain_q - 4'd1;
            if (drain_q <= 4'd1) begin
               state_d = S_RUN;
            end
         end
         default: begin
            state_d = S_RUN;
         end
      endcase

      if (take_exc) begin
         pc_we   = 1'b1;
         ifid_we = 1'b1;
         flush   = 1'b1;
         bubble  = 1'b1;
         exc_sel = 1'b1;
         drain_d = DRAIN_INIT;
         state_d = S_EXC;
      end

      stall_d = stall_q;
      if (!pc_we && (stall_q != {CNT_W{1'b1}})) begin
         stall_d = stall_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_RUN;
         drain_q   <= 4'd0;
         miss_q    <= 8'd0;
         timeout_q <= 1'b0;
         stall_q   <= '0;
      end else begin
         state_q   <= state_d;
         drain_q   <= drain_d;
         miss_q    <= miss_d;
         timeout_q <= timeout_d;
         stall_q   <= stall_d;
      end
   end

   // Reset forces the safe hold/flush pattern without waiting for an edge
   assign PCWrite           = reset ? 1'b0 : pc_we;
   assign IF_ID_Write       = reset ? 1'b1 : ifid_we;
   assign IF_ID_Flush_excep = reset ? 1'b1 : flush;
   assign ID_EX_Bubble      = reset ? 1'b1 : bubble;
   assign ExcepPCSel        = reset ? 1'b0 : exc_sel;
   assign ImemTimeout       = reset ? 1'b0 : timeout_q;
   assign StallCnt          = reset ? '0 : stall_q;

endmodule

// File: tb/tb_ifid_hazard_ctrl.sv
// Directed plus random bench for ifid_hazard_ctrl against a
// cycle-level reference model of the sequencing rules.
module tb_ifid_hazard_ctrl;

   localparam int DRAIN = 2;
   localparam int TMO   = 4;
   localparam int CW    = 16;
   localparam int SMAX  = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          reset;
   logic          IDEX_MemRead;
   logic [4:0]    IDEX_Rt, IFID_Rs, IFID_Rt;
   logic          IFID_UsesRt, ImemReady, BrMispredict, Exception;
   logic          PCWrite, IF_ID_Write, IF_ID_Flush_excep;
   logic          ID_EX_Bubble, ExcepPCSel, ImemTimeout;
   logic [CW-1:0] StallCnt;

   int n_cmp = 0;
   int n_bad = 0;

   // Model: remaining drain cycles, cycles spent in a miss (-1 = none)
   int   m_drain = 0;
   int   m_miss  = -1;
   int   m_stall = 0;
   bit   m_tmo   = 1'b0;
   logic [4:0] exp_o;
   bit   e_fire;

   ifid_hazard_ctrl #(
      .EXC_DRAIN(DRAIN),
      .MISS_TIMEOUT(TMO),
      .CNT_W(CW)
   ) dut (
      .clk(clk),
      .reset(reset),
      .IDEX_MemRead(IDEX_MemRead),
      .IDEX_Rt(IDEX_Rt),
      .IFID_Rs(IFID_Rs),
      .IFID_Rt(IFID_Rt),
      .IFID_UsesRt(IFID_UsesRt),
      .ImemReady(ImemReady),
      .BrMispredict(BrMispredict),
      .Exception(Exception),
      .PCWrite(PCWrite),
      .IF_ID_Write(IF_ID_Write),
      .IF_ID_Flush_excep(IF_ID_Flush_excep),
      .ID_EX_Bubble(ID_EX_Bubble),
      .ExcepPCSel(ExcepPCSel),
      .ImemTimeout(ImemTimeout),
      .StallCnt(StallCnt)
   );

   always #5 clk = ~clk;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic drv(bit mr, int rt, int rs, int rt2, bit uses,
                      bit rdy, bit br, bit exc);
      IDEX_MemRead = mr;
      IDEX_Rt      = 5'(rt);
      IFID_Rs      = 5'(rs);
      IFID_Rt      = 5'(rt2);
      IFID_UsesRt  = uses;
      ImemReady    = rdy;
      BrMispredict = br;
      Exception    = exc;
   endtask

   task automatic idle();
      drv(0, 0, 0, 0, 0, 1, 0, 0);
   endtask

   // exp_o = {PCWrite, IF_ID_Write, Flush, Bubble, ExcepPCSel}
   task automatic model_eval();
      bit lu;
      bit in_miss;
      lu = IDEX_MemRead && (IDEX_Rt != 5'd0) &&
           ((IDEX_Rt == IFID_Rs) || (IFID_UsesRt && (IDEX_Rt == IFID_Rt)));
      in_miss = (m_miss >= 0);
      e_fire  = 1'b0;
      if (reset || m_drain > 0) begin
         exp_o = 5'b01110;
      end else begin
         e_fire = in_miss && !Exception && !BrMispredict &&
                  !ImemReady && (m_miss == TMO - 1);
         if (Exception || e_fire)  exp_o = 5'b11111;
         else if (BrMispredict)    exp_o = 5'b11100;
         else if (!ImemReady)      exp_o = 5'b01100;
         else if (lu)              exp_o = 5'b00010;
         else                      exp_o = 5'b11000;
      end
   endtask

   task automatic model_step();
      if (reset) begin
         m_drain = 0;
         m_miss  = -1;
         m_stall = 0;
         m_tmo   = 1'b0;
      end else begin
         if (!exp_o[4] && m_stall < SMAX) m_stall++;
         if (m_drain > 0) begin
            m_drain--;
         end else if (Exception || e_fire) begin
            m_drain = DRAIN;
            m_miss  = -1;
            if (e_fire) m_tmo = 1'b1;
         end else if (BrMispredict || ImemReady) begin
            m_miss = -1;
         end else begin
            m_miss = (m_miss >= 0) ? m_miss + 1 : 0;
         end
      end
   endtask

   // Entered at posedge+1 with inputs already applied
   task automatic cyc(string tag);
      model_eval();
      @(negedge clk);
      chk({tag, ".ctl"},
          {27'd0, PCWrite, IF_ID_Write, IF_ID_Flush_excep,
           ID_EX_Bubble, ExcepPCSel},
          {27'd0, exp_o});
      chk({tag, ".tmo"}, {31'd0, ImemTimeout}, reset ? 32'd0 : {31'd0, m_tmo});
      chk({tag, ".cnt"}, {16'd0, StallCnt}, reset ? 32'd0 : 32'(m_stall));
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle();
      cyc("rst");
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      idle();
      @(posedge clk);
      #1;
      cyc("rst0");
      cyc("rst1");
      reset = 1'b0;
      idle();
      cyc("idle");
      chk("rst.cnt0", {16'd0, StallCnt}, 32'd0);

      drv(1, 5, 5, 0, 0, 1, 0, 0);
      cyc("lu");
      chk("lu.cnt1", {16'd0, StallCnt}, 32'd1);
      idle();
      cyc("lu.after");
      drv(1, 0, 0, 0, 0, 1, 0, 0);
      cyc("lu.r0");
      drv(1, 7, 3, 7, 1, 1, 0, 0);
      cyc("lu.rt");
      drv(1, 7, 3, 7, 0, 1, 0, 0);
      cyc("lu.nort");
      chk("lu.cnt2", {16'd0, StallCnt}, 32'd2);

      drv(1, 5, 5, 0, 0, 0, 1, 1);
      #3;
      chk("prio.sel", {31'd0, ExcepPCSel}, 32'd1);
      cyc("prio");
      idle();
      cyc("prio.d1");
      cyc("prio.d2");
      cyc("prio.run");

      drv(0, 0, 0, 0, 0, 1, 0, 1);
      cyc("exc0");
      idle();
      cyc("exc1");
      cyc("exc2");
      #3;
      chk("exc3.pc", {31'd0, PCWrite}, 32'd1);
      chk("exc3.fl", {31'd0, IF_ID_Flush_excep}, 32'd0);
      cyc("exc3");

      do_reset();
      for (int i = 0; i < TMO; i++) begin
         drv(0, 0, 0, 0, 0, 0, 0, 0);
         cyc("miss");
      end
      idle();
      cyc("miss.done");
      chk("miss.cnt", {16'd0, StallCnt}, 32'd4);
      chk("miss.tmo", {31'd0, ImemTimeout}, 32'd0);

      do_reset();
      drv(0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < TMO; i++) cyc("wd");
      #3;
      chk("wd.sel", {31'd0, ExcepPCSel}, 32'd1);
      cyc("wd.fire");
      chk("wd.flag", {31'd0, ImemTimeout}, 32'd1);
      cyc("wd.d1");
      cyc("wd.d2");
      idle();
      cyc("wd.run");
      chk("wd.sticky", {31'd0, ImemTimeout}, 32'd1);

      drv(0, 0, 0, 0, 0, 1, 0, 1);
      cyc("rx.exc");
      idle();
      cyc("rx.d1");
      reset = 1'b1;
      cyc("rx.rst");
      reset = 1'b0;
      cyc("rx.run");
      chk("rx.tmo", {31'd0, ImemTimeout}, 32'd0);
      chk("rx.pc", {31'd0, PCWrite}, 32'd1);

      for (int i = 0; i < 400; i++) begin
         reset = ($urandom_range(63, 0) == 0);
         drv($urandom_range(1, 0),
             $urandom_range(3, 0), $urandom_range(3, 0),
             $urandom_range(3, 0), $urandom_range(1, 0),
             $urandom_range(3, 0) != 0,
             $urandom_range(7, 0) == 0,
             (m_drain == 0) && ($urandom_range(15, 0) == 0));
         cyc("rnd");
      end
      reset = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
